// File: rtl/regfile_scoreboard.sv
// ============================================================================
// regfile_scoreboard : multi-port register file with bypass and issue scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_ready,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_rd,
  output logic                iss_stall,
  input  logic                flush,
  output logic [NREGS-1:0]    pending,
  output logic [AW:0]         pend_cnt
);

  logic [XLEN-1:0]  mem_q [NREGS];
  logic [NREGS-1:0] valid_q, valid_d;
  logic [NREGS-1:0] pending_q, pending_d;
  logic [AW:0]      pend_cnt_q, pend_cnt_d;

  logic [NREGS-1:0] hit;
  logic [XLEN-1:0]  hit_data [NREGS];
  logic             iss_accept;

  // Later ports overwrite earlier ones, so the highest-index writer wins.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      hit[r]      = 1'b0;
      hit_data[r] = '0;
      for (int j = 0; j < NWR; j++) begin
        if (r != 0 && wr_en[j] && wr_addr[AW*j +: AW] == AW'(r)) begin
          hit[r]      = 1'b1;
          hit_data[r] = wr_data[XLEN*j +: XLEN];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      logic [AW-1:0] ra;
      ra = rs_addr[AW*i +: AW];
      rs_data[XLEN*i +: XLEN] = '0;
      rs_ready[i]             = 1'b1;
      if (ra != '0) begin
        if (BYPASS != 0 && hit[ra]) begin
          rs_data[XLEN*i +: XLEN] = hit_data[ra];
        end else if (valid_q[ra]) begin
          rs_data[XLEN*i +: XLEN] = mem_q[ra];
        end
        rs_ready[i] = ~pending_q[ra] | ((BYPASS != 0) & hit[ra]);
      end
    end
  end

  // A writeback landing this cycle resolves the WAW hazard on the destination.
  always_comb begin
    iss_stall  = iss_en & (iss_rd != '0) & pending_q[iss_rd] & ~hit[iss_rd];
    iss_accept = iss_en & ~iss_stall & ~flush & (iss_rd != '0);
  end

  always_comb begin
    valid_d    = valid_q | hit;
    pend_cnt_d = '0;
    for (int r = 0; r < NREGS; r++) begin
      if (r == 0 || flush) begin
        pending_d[r] = 1'b0;
      end else if (iss_accept && iss_rd == AW'(r)) begin
        pending_d[r] = 1'b1;
      end else if (hit[r]) begin
        pending_d[r] = 1'b0;
      end else begin
        pending_d[r] = pending_q[r];
      end
      pend_cnt_d = pend_cnt_d + (AW+1)'(pending_d[r]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q    <= '0;
      pending_q  <= '0;
      pend_cnt_q <= '0;
    end else begin
      valid_q    <= valid_d;
      pending_q  <= pending_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  // Storage is deliberately left unreset; valid_q masks stale contents.
  always_ff @(posedge clk) begin
    for (int r = 1; r < NREGS; r++) begin
      if (hit[r]) begin
        mem_q[r] <= hit_data[r];
      end
    end
  end

  assign pending  = pending_q;
  assign pend_cnt = pend_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
// ============================================================================
// tb_regfile_scoreboard : directed checks of regfile_scoreboard (bypass and non-bypass builds)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_regfile_scoreboard;
  localparam int XLEN = 32, NREGS = 32, NRD = 2, NWR = 2, AW = 5;

  logic clk = 1'b0;
  logic reset;
  logic [NRD*AW-1:0]   rs_addr;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_en, flush;
  logic [AW-1:0]       iss_rd;

  logic [NRD*XLEN-1:0] rs_data, nb_rs_data;
  logic [NRD-1:0]      rs_ready, nb_rs_ready;
  logic                iss_stall, nb_iss_stall;
  logic [NREGS-1:0]    pending, nb_pending;
  logic [AW:0]         pend_cnt, nb_pend_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .rs_addr(rs_addr), .rs_data(rs_data), .rs_ready(rs_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_rd(iss_rd),
    .iss_stall(iss_stall), .flush(flush), .pending(pending), .pend_cnt(pend_cnt)
  );

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .rs_addr(rs_addr), .rs_data(nb_rs_data), .rs_ready(nb_rs_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_rd(iss_rd),
    .iss_stall(nb_iss_stall), .flush(flush), .pending(nb_pending), .pend_cnt(nb_pend_cnt)
  );

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_rd = '0; flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int port, input logic [AW-1:0] a);
    rs_addr[AW*port +: AW] = a;
  endtask

  task automatic set_wr(input int port, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wr_en[port]                = 1'b1;
    wr_addr[AW*port +: AW]     = a;
    wr_data[XLEN*port +: XLEN] = d;
  endtask

  task automatic issue(input logic [AW-1:0] a);
    iss_en = 1'b1; iss_rd = a;
    step();
    idle();
  endtask

  task automatic test_reset();
    reset = 1'b0; rs_addr = '0; idle();
    step(); step();
    reset = 1'b1;
    set_rd(0, 5);
    #1;
    vectors++;
    if (pending !== 32'h0) begin miscompares++; $display("FAIL reset_pending got %h exp %h", pending, 32'h0); end
    vectors++;
    if (pend_cnt !== 6'd0) begin miscompares++; $display("FAIL reset_cnt got %0d exp 0", pend_cnt); end
    vectors++;
    if (rs_data[31:0] !== 32'h0) begin miscompares++; $display("FAIL reset_read_x5 got %h exp 0", rs_data[31:0]); end
    issue(7);
    vectors++;
    if (pending !== 32'h80) begin miscompares++; $display("FAIL pre_async_pending got %h exp %h", pending, 32'h80); end
    #3 reset = 1'b0;
    #1;
    vectors++;
    if (pending !== 32'h0) begin miscompares++; $display("FAIL async_reset_pending got %h exp 0", pending); end
    vectors++;
    if (pend_cnt !== 6'd0) begin miscompares++; $display("FAIL async_reset_cnt got %0d exp 0", pend_cnt); end
    step();
    reset = 1'b1;
  endtask

  task automatic test_write_priority();
    set_wr(0, 3, 32'h11);
    set_wr(1, 3, 32'h22);
    set_rd(0, 3);
    #1;
    vectors++;
    if (rs_data[31:0] !== 32'h22) begin miscompares++; $display("FAIL bypass_prio got %h exp 22", rs_data[31:0]); end
    vectors++;
    if (nb_rs_data[31:0] !== 32'h0) begin miscompares++; $display("FAIL nb_prio_same_cycle got %h exp 0", nb_rs_data[31:0]); end
    step(); idle();
    #1;
    vectors++;
    if (rs_data[31:0] !== 32'h22) begin miscompares++; $display("FAIL storage_prio got %h exp 22", rs_data[31:0]); end
    vectors++;
    if (nb_rs_data[31:0] !== 32'h22) begin miscompares++; $display("FAIL nb_storage_prio got %h exp 22", nb_rs_data[31:0]); end
  endtask

  task automatic test_pending_clear();
    issue(7);
    set_rd(1, 7);
    #1;
    vectors++;
    if (pending !== 32'h80) begin miscompares++; $display("FAIL issue_pending got %h exp 80", pending); end
    vectors++;
    if (pend_cnt !== 6'd1) begin miscompares++; $display("FAIL issue_cnt got %0d exp 1", pend_cnt); end
    vectors++;
    if (rs_ready[1] !== 1'b0) begin miscompares++; $display("FAIL ready_pending got %b exp 0", rs_ready[1]); end
    set_wr(0, 7, 32'hAB);
    #1;
    vectors++;
    if (rs_ready[1] !== 1'b1) begin miscompares++; $display("FAIL ready_bypass got %b exp 1", rs_ready[1]); end
    vectors++;
    if (rs_data[63:32] !== 32'hAB) begin miscompares++; $display("FAIL data_bypass got %h exp ab", rs_data[63:32]); end
    vectors++;
    if (nb_rs_ready[1] !== 1'b0) begin miscompares++; $display("FAIL nb_ready_no_bypass got %b exp 0", nb_rs_ready[1]); end
    step(); idle();
    vectors++;
    if (pending !== 32'h0) begin miscompares++; $display("FAIL clear_pending got %h exp 0", pending); end
    vectors++;
    if (pend_cnt !== 6'd0) begin miscompares++; $display("FAIL clear_cnt got %0d exp 0", pend_cnt); end
  endtask

  task automatic test_stall();
    issue(7);
    iss_en = 1'b1; iss_rd = 7;
    #1;
    vectors++;
    if (iss_stall !== 1'b1) begin miscompares++; $display("FAIL waw_stall got %b exp 1", iss_stall); end
    step(); idle();
    vectors++;
    if (pend_cnt !== 6'd1) begin miscompares++; $display("FAIL stall_hold_cnt got %0d exp 1", pend_cnt); end
    iss_en = 1'b1; iss_rd = 7;
    set_wr(1, 7, 32'h55);
    #1;
    vectors++;
    if (iss_stall !== 1'b0) begin miscompares++; $display("FAIL stall_with_write got %b exp 0", iss_stall); end
    step(); idle();
    set_rd(0, 7);
    #1;
    vectors++;
    if (pending !== 32'h80) begin miscompares++; $display("FAIL set_beats_clear got %h exp 80", pending); end
    vectors++;
    if (rs_data[31:0] !== 32'h55) begin miscompares++; $display("FAIL stall_write_data got %h exp 55", rs_data[31:0]); end
    set_wr(0, 7, 32'h66);
    step(); idle();
    vectors++;
    if (pend_cnt !== 6'd0) begin miscompares++; $display("FAIL stall_drain_cnt got %0d exp 0", pend_cnt); end
  endtask

  task automatic test_flush();
    issue(1); issue(2); issue(3);
    vectors++;
    if (pending !== 32'hE) begin miscompares++; $display("FAIL three_pending got %h exp e", pending); end
    vectors++;
    if (pend_cnt !== 6'd3) begin miscompares++; $display("FAIL three_cnt got %0d exp 3", pend_cnt); end
    flush = 1'b1;
    iss_en = 1'b1; iss_rd = 4;
    set_wr(0, 9, 32'h5);
    step(); idle();
    set_rd(0, 9);
    #1;
    vectors++;
    if (pending !== 32'h0) begin miscompares++; $display("FAIL flush_pending got %h exp 0", pending); end
    vectors++;
    if (pend_cnt !== 6'd0) begin miscompares++; $display("FAIL flush_cnt got %0d exp 0", pend_cnt); end
    vectors++;
    if (rs_data[31:0] !== 32'h5) begin miscompares++; $display("FAIL flush_write got %h exp 5", rs_data[31:0]); end
  endtask

  task automatic test_x0_and_no_bypass();
    set_wr(1, 0, 32'hFF);
    iss_en = 1'b1; iss_rd = 0;
    set_rd(0, 0);
    #1;
    vectors++;
    if (rs_data[31:0] !== 32'h0) begin miscompares++; $display("FAIL x0_read got %h exp 0", rs_data[31:0]); end
    vectors++;
    if (rs_ready[0] !== 1'b1) begin miscompares++; $display("FAIL x0_ready got %b exp 1", rs_ready[0]); end
    vectors++;
    if (iss_stall !== 1'b0) begin miscompares++; $display("FAIL x0_stall got %b exp 0", iss_stall); end
    step(); idle();
    #1;
    vectors++;
    if (pending !== 32'h0) begin miscompares++; $display("FAIL x0_pending got %h exp 0", pending); end
    vectors++;
    if (rs_data[31:0] !== 32'h0) begin miscompares++; $display("FAIL x0_after_write got %h exp 0", rs_data[31:0]); end
    set_wr(0, 4, 32'h9);
    set_rd(0, 4);
    #1;
    vectors++;
    if (nb_rs_data[31:0] !== 32'h0) begin miscompares++; $display("FAIL nb_same_cycle got %h exp 0", nb_rs_data[31:0]); end
    vectors++;
    if (rs_data[31:0] !== 32'h9) begin miscompares++; $display("FAIL byp_same_cycle got %h exp 9", rs_data[31:0]); end
    step(); idle();
    #1;
    vectors++;
    if (nb_rs_data[31:0] !== 32'h9) begin miscompares++; $display("FAIL nb_next_cycle got %h exp 9", nb_rs_data[31:0]); end
  endtask

  initial begin
    test_reset();
    test_write_priority();
    test_pending_clear();
    test_stall();
    test_flush();
    test_x0_and_no_bypass();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
